hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Sequences the 5-stage pipeline around the main control decoder's outputs.
- Generates PC/IF-ID write enables, stage flushes and whole-pipe freezes for four cases: load-use hazards, taken branches (beq/bne resolved in EX), jumps (decoded in ID) and multi-cycle data-memory accesses.
- Contains a memory-wait FSM with a timeout, plus saturating stall/flush performance counters.
- Sits beside the pipeline registers; its outputs gate every stage-register write.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before the error trap.
- TO_W, 8: width of the timeout counter; must satisfy MEM_TIMEOUT < 2^TO_W.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, bne, sw)
- id_jump  in  1  Jump from the main control, ID stage
- ex_memread  in  1  MemRead in ID/EX
- ex_rt  in  5  destination rt of the ID/EX instruction
- ex_branch_taken  in  1  branch condition true in EX (Branch=01 & zero, or Branch=10 & !zero)
- mem_req  in  1  EX/MEM instruction has MemRead or MemWrite
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_flush  out  1  ID/EX loads a bubble (all control zero)
- pipe_freeze  out  1  hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB loads a bubble
- mem_timeout_err  out  1  sticky error flag
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
- flush_events  out  CNT_W  saturating count of cycles with ifid_flush=1

Behaviour:
- State register: RUN, MEM_WAIT, ERR. Reset (rst_n=0 at a clk edge) → RUN, wait counter 0, mem_timeout_err 0, both perf counters 0.
- While rst_n=0, all outputs are forced: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0, pipe_freeze=0.
- Flush/stall outputs are combinational from the current state and inputs, so they act in the same cycle. The state and counters are registered.
- Derived terms:
  - load_use = ex_memread & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt))
  - wait = (state==RUN & mem_req & !mem_ready) | (state==MEM_WAIT & !mem_ready) | state==ERR
- Output priority, highest first:
  1. wait: pipe_freeze=1, pc_write=0, ifid_write=0, no flushes. A pending branch or jump stays frozen in its stage and is acted on after release.
  2. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. This overrides load_use and id_jump.
  3. load_use: pc_write=0, ifid_write=0, idex_flush=1. One bubble per hazard.
  4. id_jump: pc_write=1, ifid_write=1, ifid_flush=1.
  5. Otherwise: pc_write=1, ifid_write=1, all flushes 0.
- FSM transitions:
  - RUN → MEM_WAIT when mem_req & !mem_ready; the wait counter loads 1.
  - RUN with mem_req & mem_ready: a zero-wait access; stay in RUN with no freeze.
  - MEM_WAIT → RUN on mem_ready, with the counter cleared. The freeze drops in that same cycle.
  - MEM_WAIT with !mem_ready: the counter increments. When the counter equals MEM_TIMEOUT and mem_ready=0, go to ERR and set mem_timeout_err.
  - ERR: permanent freeze; only reset exits.
- mem_req is sampled only in RUN. mem_req dropping during MEM_WAIT does not end the wait; only mem_ready does.
- Perf counters increment on clock edges where the condition holds and rst_n=1. They saturate at all-ones and never wrap.
- Reset mid-wait: the FSM returns to RUN next cycle, with no residual freeze.

Decomposition:
- Shared pipeline package holds:
  - the state encoding (RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10)
  - REG_ZERO=5'd0
  - opcode constants already used by the main control (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J), used by the ID logic producing id_uses_rt
- One sub-module, sat_counter (width parameter, inc, synchronous active-low clear), instantiated twice for the perf counters.

Test Plan:
- lw $2 in EX (ex_memread=1, ex_rt=2), ID add with rs=2 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; the next cycle is normal; stall_cycles=1.
- Same as above but ex_rt=0, or ex_rt=2 matching id_rt with id_uses_rt=0 → no stall.
- ex_branch_taken=1 together with load_use=1 and id_jump=1 → pc_write=1, ifid_flush=1, idex_flush=1 for one cycle; flush_events increments by 1.
- mem_req=1, mem_ready low for 3 cycles then high → pipe_freeze=1 for exactly 3 cycles, 0 in the ready cycle; state returns to RUN; stall_cycles +3.
- MEM_TIMEOUT=4, mem_ready held low → freeze; ERR entered after 4 wait cycles; mem_timeout_err=1 and held; rst_n=0 for one edge clears it, and the FSM is in RUN.
- Force 2^CNT_W+5 load-use stalls (CNT_W=4 build) → stall_cycles saturates at 15 and does not wrap.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared pipeline definitions used by the hazard/stall controller and by the
//   ID-stage logic that feeds it.
//   - state_e      : memory-wait FSM encoding
//   - REG_ZERO     : register number of the hard-wired zero register
//   - OP_*         : primary opcodes also used by the main control decoder
//   - uses_rt()    : true when an opcode reads the rt register as a source
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type reads rt as its second operand, branches compare rs with rt and
    // sw stores rt. lw and j never read rt, so they cannot hazard on it.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the performance counters.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   synchronous active-low clear
//     inc    in   count this cycle
//     count  out  current value; sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Pipeline sequencer for the 5-stage core. Produces the PC / IF-ID write
//   enables, IF-ID and ID-EX flushes and the whole-pipe freeze for load-use
//   hazards, taken branches (resolved in EX), jumps (decoded in ID) and
//   multi-cycle data-memory accesses. A memory-wait FSM traps into a sticky
//   error state if the memory never answers.
//
//   Ports:
//     clk, rst_n        clock / synchronous active-low reset
//     id_rs, id_rt      source register fields of the ID instruction
//     id_uses_rt        ID instruction reads rt
//     id_jump           ID instruction is a jump
//     ex_memread, ex_rt load in EX and its destination register
//     ex_branch_taken   branch in EX resolved taken
//     mem_req           EX/MEM instruction accesses data memory
//     mem_ready         data memory finishes the access this cycle
//     pc_write          PC may update
//     ifid_write        IF/ID may load
//     ifid_flush        IF/ID loads a NOP
//     idex_flush        ID/EX loads a bubble
//     pipe_freeze       hold PC..EX/MEM, bubble into MEM/WB
//     mem_timeout_err   sticky memory-timeout flag
//     stall_cycles      saturating count of cycles with pc_write=0
//     flush_events      saturating count of cycles with ifid_flush=1
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] CNT_ONE     = TO_W'(1);

    state_e          state_q,    state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            err_q,      err_d;

    logic            load_use;
    logic            mem_wait;

    // -----------------------------------------------------------------------
    // Hazard terms
    // -----------------------------------------------------------------------
    // A load into the zero register never produces a value, so it cannot
    // create a dependency even if the ID instruction names $0.
    always_comb begin
        load_use = ex_memread && (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    // The freeze is raised in the very cycle the access misses, before the
    // FSM has left RUN, so the stalled instruction is never lost.
    always_comb begin
        mem_wait = ((state_q == ST_RUN) && mem_req && !mem_ready) ||
                   ((state_q == ST_MEM_WAIT) && !mem_ready) ||
                   (state_q == ST_ERR);
    end

    // -----------------------------------------------------------------------
    // Stage control outputs (same-cycle, priority ordered)
    // -----------------------------------------------------------------------
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;

        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (mem_wait) begin
            // Branches/jumps stay frozen in place and are handled on release.
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (ex_branch_taken) begin
            // The instructions in IF and ID are on the wrong path, so any
            // hazard or jump they carry is irrelevant.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Hold IF and ID one cycle; the bubble lets the load reach MEM/WB
            // so forwarding can supply the value on the next cycle.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Memory-wait FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;

        case (state_q)
            ST_RUN: begin
                // mem_req is only looked at here; once waiting, only
                // mem_ready can release the pipe.
                if (mem_req && !mem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_VAL) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                // Dead memory: hold everything until reset.
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Directed bench: a table of single-cycle vectors for the output priority
//   plus hand-written sequences for stalls, memory waits, timeout, reset and
//   counter saturation. Built with MEM_TIMEOUT=4 and CNT_W=4.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 8;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, id_jump, ex_memread, ex_branch_taken;
    logic             mem_req, mem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .pipe_freeze     (pipe_freeze),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}
    localparam logic [4:0] O_NORM   = 5'b11000;
    localparam logic [4:0] O_LU     = 5'b00010;
    localparam logic [4:0] O_BR     = 5'b11110;
    localparam logic [4:0] O_JMP    = 5'b11100;
    localparam logic [4:0] O_FREEZE = 5'b00001;
    localparam logic [4:0] O_RST    = 5'b00000;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       req;
        logic       rdy;
        logic [4:0] exp_out;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [4:0] outs();
        return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // lw $2 in EX, add with rs=$2 in ID
    task automatic drive_load_use();
        id_rs = 5'd2; id_rt = 5'd3; id_uses_rt = uses_rt(OP_RTYPE);
        ex_memread = 1'b1; ex_rt = 5'd2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic vec_t mk(input string n, input logic [4:0] rs, input logic [4:0] rt,
                                input logic ur, input logic j, input logic mr,
                                input logic [4:0] ert, input logic br, input logic rq,
                                input logic rd, input logic [4:0] e);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.jump = j; v.memread = mr;
        v.ex_rt = ert; v.br = br; v.req = rq; v.rdy = rd; v.exp_out = e;
        return v;
    endfunction

    initial begin
        //                name          rs  rt  ur j  mr ert br rq rd  expected
        vecs[0]  = mk("lu_rs",          2,  3,  1, 0, 1, 2,  0, 0, 0, O_LU);
        vecs[1]  = mk("lu_rt0",         0,  0,  1, 0, 1, 0,  0, 0, 0, O_NORM);
        vecs[2]  = mk("rt_not_used",    5,  2,  0, 0, 1, 2,  0, 0, 0, O_NORM);
        vecs[3]  = mk("lu_rt",          5,  2,  1, 0, 1, 2,  0, 0, 0, O_LU);
        vecs[4]  = mk("no_memread",     2,  2,  1, 0, 0, 2,  0, 0, 0, O_NORM);
        vecs[5]  = mk("br_over_all",    2,  3,  1, 1, 1, 2,  1, 0, 0, O_BR);
        vecs[6]  = mk("jump",           4,  6,  0, 1, 0, 0,  0, 0, 0, O_JMP);
        vecs[7]  = mk("lu_over_jump",   7,  1,  0, 1, 1, 7,  0, 0, 0, O_LU);
        vecs[8]  = mk("branch",         1,  1,  1, 0, 0, 0,  1, 0, 0, O_BR);
        vecs[9]  = mk("idle",           0,  0,  0, 0, 0, 0,  0, 0, 0, O_NORM);
        vecs[10] = mk("zero_wait_jump", 0,  0,  0, 1, 0, 0,  0, 1, 1, O_JMP);
        vecs[11] = mk("miss_over_br",   2,  3,  1, 1, 1, 2,  1, 1, 0, O_FREEZE);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle_inputs();
        drive_load_use();
        id_jump = 1'b1;
        #2;
        chk("rst_outputs_forced", 16'(outs()), 16'(O_RST));
        tick();
        chk("rst_stall_cnt", 16'(stall_cycles), 16'd0);
        chk("rst_flush_cnt", 16'(flush_events), 16'd0);
        chk("rst_err", 16'(mem_timeout_err), 16'd0);
        rst_n = 1'b1;
        idle_inputs();
        #1;
        chk("post_rst_normal", 16'(outs()), 16'(O_NORM));

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            id_jump = vecs[i].jump; ex_memread = vecs[i].memread; ex_rt = vecs[i].ex_rt;
            ex_branch_taken = vecs[i].br; mem_req = vecs[i].req; mem_ready = vecs[i].rdy;
            #1;
            $display("vec %0d %s: outs=%05b exp=%05b", i, vecs[i].name, outs(), vecs[i].exp_out);
            chk(vecs[i].name, 16'(outs()), 16'(vecs[i].exp_out));
            tick();
        end

        // ---------------- load-use: one bubble ----------------
        do_reset();
        drive_load_use();
        #1;
        chk("lu_seq_stall", 16'(outs()), 16'(O_LU));
        tick();
        idle_inputs();   // bubble now in EX
        #1;
        chk("lu_seq_resume", 16'(outs()), 16'(O_NORM));
        chk("lu_seq_stall_cnt", 16'(stall_cycles), 16'd1);
        $display("seq load_use: stall_cycles=%0d", stall_cycles);

        // ---------------- branch beats load-use and jump ----------------
        do_reset();
        drive_load_use();
        id_jump = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        chk("br_seq_outs", 16'(outs()), 16'(O_BR));
        tick();
        idle_inputs();
        #1;
        chk("br_seq_flush_cnt", 16'(flush_events), 16'd1);
        chk("br_seq_stall_cnt", 16'(stall_cycles), 16'd0);
        $display("seq branch: flush_events=%0d", flush_events);

        // ---------------- 3-cycle memory wait ----------------
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("mw_c1_freeze", 16'(outs()), 16'(O_FREEZE));
        tick();
        mem_req = 1'b0; ex_branch_taken = 1'b1;   // req drop and pending branch
        #1;
        chk("mw_c2_freeze", 16'(outs()), 16'(O_FREEZE));
        tick();
        #1;
        chk("mw_c3_freeze", 16'(outs()), 16'(O_FREEZE));
        tick();
        mem_ready = 1'b1;
        #1;
        chk("mw_ready_branch", 16'(outs()), 16'(O_BR));
        tick();
        idle_inputs();
        #1;
        chk("mw_back_run", 16'(outs()), 16'(O_NORM));
        chk("mw_stall_cnt", 16'(stall_cycles), 16'd3);
        chk("mw_flush_cnt", 16'(flush_events), 16'd1);
        $display("seq mem_wait: stall_cycles=%0d flush_events=%0d", stall_cycles, flush_events);

        // ---------------- timeout into ERR ----------------
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT; i++) tick();
        chk("to_not_yet_err", 16'(mem_timeout_err), 16'd0);
        chk("to_still_frozen", 16'(outs()), 16'(O_FREEZE));
        tick();
        chk("to_err_set", 16'(mem_timeout_err), 16'd1);
        mem_req = 1'b0; mem_ready = 1'b1;
        #1;
        chk("to_err_frozen", 16'(outs()), 16'(O_FREEZE));
        tick();
        chk("to_err_sticky", 16'(mem_timeout_err), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("to_rst_forced", 16'(outs()), 16'(O_RST));
        tick();
        rst_n = 1'b1;
        idle_inputs();
        #1;
        chk("to_rst_err_clr", 16'(mem_timeout_err), 16'd0);
        chk("to_rst_run", 16'(outs()), 16'(O_NORM));
        $display("seq timeout: err cleared=%0d", !mem_timeout_err);

        // ---------------- reset mid-wait ----------------
        do_reset();
        mem_req = 1'b1;
        tick();
        mem_req = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("midwait_rst_run", 16'(outs()), 16'(O_NORM));
        $display("seq reset mid-wait: outs=%05b", outs());

        // ---------------- counter saturation ----------------
        do_reset();
        drive_load_use();
        for (int i = 0; i < 14; i++) tick();
        chk("sat_counting", 16'(stall_cycles), 16'd14);
        for (int i = 14; i < (1 << CNT_W) + 5; i++) tick();
        chk("sat_no_wrap", 16'(stall_cycles), 16'd15);
        $display("seq saturation: stall_cycles=%0d", stall_cycles);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
